// File: rtl/fcmp_unit.sv
// Two-stage pipelined single-precision compare (FEQ/FLT/FLE/FGT) with flush-to-zero
// operand semantics, valid/ready handshake on both sides and a passthrough tag.
module fcmp_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_srca,
  input  logic [31:0]      in_srcb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;
  localparam logic [1:0] OP_FGT = 2'b11;

  // a < b from the reduced operand flags; zeros ignore sign, Inf/NaN are plain magnitudes.
  function automatic logic flt_flags(input logic za, input logic zb,
                                     input logic sa, input logic sb,
                                     input logic mag_lt, input logic mag_gt);
    logic r;
    if (za && zb) begin
      r = 1'b0;
    end else if (za) begin
      r = ~sb;
    end else if (zb) begin
      r = sa;
    end else if (sa != sb) begin
      r = sa;
    end else if (!sa) begin
      r = mag_lt;
    end else begin
      r = mag_gt;
    end
    return r;
  endfunction

  logic             adv1_s;
  logic             adv2_s;
  logic             za_s;
  logic             zb_s;
  logic             mag_lt_s;
  logic             mag_gt_s;
  logic             bit_eq_s;
  logic             feq_s;
  logic             flt_ab_s;
  logic             flt_ba_s;
  logic             cmp_s;

  logic             s1_valid_r;
  logic [1:0]       s1_op_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic             s1_za_r;
  logic             s1_zb_r;
  logic             s1_sa_r;
  logic             s1_sb_r;
  logic             s1_mag_lt_r;
  logic             s1_mag_gt_r;
  logic             s1_bit_eq_r;
  logic             s2_valid_r;
  logic [31:0]      s2_result_r;
  logic [TAG_W-1:0] s2_tag_r;

  assign adv2_s     = ~s2_valid_r | out_ready;
  assign adv1_s     = ~s1_valid_r | adv2_s;
  assign in_ready   = adv1_s;
  assign out_valid  = s2_valid_r;
  assign out_result = s2_result_r;
  assign out_tag    = s2_tag_r;

  assign za_s     = (in_srca[30:23] == 8'd0);
  assign zb_s     = (in_srcb[30:23] == 8'd0);
  assign mag_lt_s = (in_srca[30:0] < in_srcb[30:0]);
  assign mag_gt_s = (in_srca[30:0] > in_srcb[30:0]);
  assign bit_eq_s = (in_srca == in_srcb);

  // Stage-2 combine of the registered stage-1 flags into the compare bit.
  always_comb begin
    feq_s    = (s1_za_r & s1_zb_r) | (s1_bit_eq_r & ~s1_za_r & ~s1_zb_r);
    flt_ab_s = flt_flags(s1_za_r, s1_zb_r, s1_sa_r, s1_sb_r, s1_mag_lt_r, s1_mag_gt_r);
    flt_ba_s = flt_flags(s1_zb_r, s1_za_r, s1_sb_r, s1_sa_r, s1_mag_gt_r, s1_mag_lt_r);
    cmp_s    = 1'b0;
    case (s1_op_r)
      OP_FEQ:  cmp_s = feq_s;
      OP_FLT:  cmp_s = flt_ab_s;
      OP_FLE:  cmp_s = flt_ab_s | feq_s;
      OP_FGT:  cmp_s = flt_ba_s;
      default: cmp_s = 1'b0;
    endcase
  end

  // Stage 1: capture the op, tag and the reduced operand flags on accept.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_r  <= 1'b0;
      s1_op_r     <= 2'b00;
      s1_tag_r    <= '0;
      s1_za_r     <= 1'b0;
      s1_zb_r     <= 1'b0;
      s1_sa_r     <= 1'b0;
      s1_sb_r     <= 1'b0;
      s1_mag_lt_r <= 1'b0;
      s1_mag_gt_r <= 1'b0;
      s1_bit_eq_r <= 1'b0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_op_r     <= in_op;
        s1_tag_r    <= in_tag;
        s1_za_r     <= za_s;
        s1_zb_r     <= zb_s;
        s1_sa_r     <= in_srca[31];
        s1_sb_r     <= in_srcb[31];
        s1_mag_lt_r <= mag_lt_s;
        s1_mag_gt_r <= mag_gt_s;
        s1_bit_eq_r <= bit_eq_s;
      end
    end
  end

  // Stage 2: registered result and tag; held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= 32'd0;
      s2_tag_r    <= '0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_result_r <= {31'd0, cmp_s};
        s2_tag_r    <= s1_tag_r;
      end
    end
  end

endmodule

// File: tb/tb_fcmp_unit.sv
// Self-checking bench for fcmp_unit: directed and randomized compares scored against
// a signed-key reference model, with latency, backpressure and reset-flush checks.
module tb_fcmp_unit;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_srca;
  logic [31:0]      in_srcb;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  fcmp_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_srca(in_srca), .in_srcb(in_srcb), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t             q[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  bit               lat_en = 1'b1;
  bit               rnd_ready = 1'b0;
  bit               accepted = 1'b0;
  bit               prev_rst = 1'b0;
  bit               hold_pend = 1'b0;
  bit               cur_use = 1'b0;
  bit               cur_dir = 1'b0;
  logic [31:0]      held_res;
  logic [TAG_W-1:0] held_tag;

  // Every operand maps to a signed key: zero-exponent values collapse to 0, others are +/-magnitude.
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'({33'd0, x[30:0]});
    if (x[30:23] == 8'd0) return 64'sd0;
    return x[31] ? -m : m;
  endfunction

  function automatic logic ref_cmp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    ka = fkey(a);
    kb = fkey(b);
    case (op)
      2'd0:    return ka == kb;
      2'd1:    return ka < kb;
      2'd2:    return ka <= kb;
      default: return ka > kb;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand(input logic [31:0] other);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
      1:       v = other;
      2:       v = {~other[31], other[30:0]};
      3:       v = other + 32'($urandom_range(0, 3)) - 32'd1;
      4:       v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock: sample/score at the falling edge, then advance past the rising edge.
  task automatic tick();
    exp_t e;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    accepted = 1'b0;
    @(negedge clk);
    if (!rstn) begin
      if (prev_rst) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
      end
    end else begin
      chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      if (q.size() == 0) chk("idle_out_valid", 32'(out_valid), 32'd0);
      else if (lat_en && q[0].lat && cyc >= q[0].acc + 2) chk("latency_valid", 32'(out_valid), 32'd1);
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", out_result, held_res);
        chk("hold_tag", 32'(out_tag), 32'(held_tag));
      end
      hold_pend = out_valid && !out_ready;
      held_res  = out_result;
      held_tag  = out_tag;
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("result", out_result, e.res);
        chk("tag", 32'(out_tag), 32'(e.tag));
        if (lat_en && e.lat) chk("latency", 32'(cyc), 32'(e.acc + 2));
      end
      if (in_valid && in_ready) begin
        e.res = {31'd0, cur_use ? cur_dir : ref_cmp(in_op, in_srca, in_srcb)};
        e.tag = in_tag;
        e.acc = cyc;
        e.lat = lat_en;
        q.push_back(e);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    prev_rst = !rstn;
    if (!rstn) begin
      q.delete();
      hold_pend = 1'b0;
    end
    #1;
  endtask

  task automatic send_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input bit use_dir, input bit dir);
    in_valid = 1'b1;
    in_op    = op;
    in_srca  = a;
    in_srcb  = b;
    in_tag   = tag;
    cur_use  = use_dir;
    cur_dir  = dir;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    cur_use  = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (q.size() == 0) break;
      tick();
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          nxt;

    rstn = 1'b0; in_valid = 1'b1; in_op = 2'd1;
    in_srca = 32'h3F80_0000; in_srcb = 32'h4000_0000; in_tag = 5'd31; out_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b1; in_valid = 1'b0;
    tick();
    tick();

    // Zero/denormal and sign/magnitude directed cases, back to back.
    send_op(2'd1, 32'h8000_0000, 32'h0000_0000, 5'd1, 1'b1, 1'b0);
    send_op(2'd0, 32'h8000_0000, 32'h0000_0000, 5'd2, 1'b1, 1'b1);
    send_op(2'd1, 32'h0000_0001, 32'h3F80_0000, 5'd3, 1'b1, 1'b1);
    send_op(2'd1, 32'h3F80_0000, 32'h0040_0000, 5'd4, 1'b1, 1'b0);
    send_op(2'd1, 32'hBF80_0000, 32'hC000_0000, 5'd5, 1'b1, 1'b0);
    send_op(2'd3, 32'hBF80_0000, 32'hC000_0000, 5'd6, 1'b1, 1'b1);
    send_op(2'd2, 32'h4040_0000, 32'h4040_0000, 5'd7, 1'b1, 1'b1);
    send_op(2'd1, 32'hC000_0000, 32'h3F80_0000, 5'd8, 1'b1, 1'b1);
    drain();

    // Back-to-back throughput, tags 0..7.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = rnd_operand(a);
      send_op(2'($urandom_range(0, 3)), a, b, 5'(i), 1'b0, 1'b0);
    end
    drain();

    // Five-cycle downstream stall in the middle of a continuous stream.
    lat_en = 1'b0;
    nxt = 0;
    a = $urandom;
    in_valid = 1'b1; in_op = 2'($urandom_range(0, 3)); in_srca = a; in_srcb = rnd_operand(a); in_tag = 5'd10;
    for (int c = 0; c < 16 && nxt < 10; c++) begin
      out_ready = (c >= 2 && c < 7) ? 1'b0 : 1'b1;
      tick();
      if (accepted) begin
        nxt++;
        a = $urandom;
        in_op = 2'($urandom_range(0, 3)); in_srca = a; in_srcb = rnd_operand(a); in_tag = 5'(10 + nxt);
      end
    end
    out_ready = 1'b1;
    drain();

    // Randomized traffic with random backpressure and input bubbles.
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      a = rnd_operand($urandom);
      b = rnd_operand(a);
      send_op(2'($urandom_range(0, 3)), a, b, 5'(i), 1'b0, 1'b0);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with both stages full; nothing from before the reset may emerge.
    out_ready = 1'b0;
    send_op(2'd1, 32'h3F80_0000, 32'h4000_0000, 5'd20, 1'b0, 1'b0);
    send_op(2'd0, 32'h4040_0000, 32'h4040_0000, 5'd21, 1'b0, 1'b0);
    in_valid = 1'b1; in_tag = 5'd22;
    rstn = 1'b0;
    tick();
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1; lat_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      a = rnd_operand($urandom);
      b = rnd_operand(a);
      send_op(2'($urandom_range(0, 3)), a, b, 5'(i), 1'b0, 1'b0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
